// File: rtl/timer_ctrl_pkg.sv
// Shared register map and bit positions for the timer controller.
package timer_ctrl_pkg;

  localparam logic [1:0] TC_CTRL = 2'd0;
  localparam logic [1:0] TC_CNT  = 2'd1;
  localparam logic [1:0] TC_CMP  = 2'd2;
  localparam logic [1:0] TC_STAT = 2'd3;

  localparam int TC_EN        = 0;
  localparam int TC_ONESHOT   = 1;
  localparam int TC_SRC       = 2;
  localparam int TC_IE        = 3;
  localparam int TC_PRESC_LSB = 8;

  localparam int TC_ST_MATCH = 0;
  localparam int TC_ST_RUN   = 1;

endpackage

// File: rtl/timer_ctrl_cntreg.sv
// Counter datapath: load has priority over increment; wraps modulo 2^WIDTH.
module cntreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  input  logic             cen,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      dout <= '0;
    else if (wen) dout <= din;
    else if (cen) dout <= dout + WIDTH'(1);
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: prescaler / tin edge tick source, compare-match reload,
// four-register CPU interface and level interrupt.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wr,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic             tin,
  output logic             irq
);

  localparam int PL = TC_PRESC_LSB;

  logic             r_en, r_oneshot, r_src, r_ie;
  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_cmp;
  logic             r_match;
  logic [PW-1:0]    r_pcnt;
  logic             r_sync1, r_sync2, r_sync3;
  logic             r_tick;
  logic             r_irq;

  logic             w_wr, w_wr_ctrl, w_wr_cnt, w_wr_cmp, w_wr_stat;
  logic             w_tick, w_match, w_presc_chg, w_tin_rise;
  logic             w_en_nxt, w_ie_nxt, w_match_nxt;
  logic             w_wen, w_cen;
  logic [WIDTH-1:0] w_din, w_dout;

  assign w_wr      = cs & wr;
  assign w_wr_ctrl = w_wr && (addr == TC_CTRL);
  assign w_wr_cnt  = w_wr && (addr == TC_CNT);
  assign w_wr_cmp  = w_wr && (addr == TC_CMP);
  assign w_wr_stat = w_wr && (addr == TC_STAT);

  // r_tick is decided a cycle early; gating with r_en drops it once EN falls
  assign w_tick     = r_tick & r_en;
  assign w_match    = w_tick & ~w_wr_cnt & (w_dout == r_cmp);
  assign w_tin_rise = r_sync2 & ~r_sync3;
  assign w_presc_chg = w_wr_ctrl && (wdata[PL +: PW] != r_presc);

  always_comb begin
    w_wen = 1'b0;
    w_din = '0;
    w_cen = 1'b0;
    if (w_wr_cnt) begin
      w_wen = 1'b1;
      w_din = wdata;
    end else if (w_match) begin
      w_wen = 1'b1;
    end else if (w_tick) begin
      w_cen = 1'b1;
    end
  end

  assign w_en_nxt    = w_wr_ctrl ? wdata[TC_EN] : ((w_match & r_oneshot) ? 1'b0 : r_en);
  assign w_ie_nxt    = w_wr_ctrl ? wdata[TC_IE] : r_ie;
  assign w_match_nxt = w_match | (r_match & ~(w_wr_stat & wdata[TC_ST_MATCH]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_src     <= 1'b0;
      r_ie      <= 1'b0;
      r_presc   <= '0;
      r_cmp     <= '0;
      r_match   <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_en    <= w_en_nxt;
      r_ie    <= w_ie_nxt;
      r_match <= w_match_nxt;
      r_irq   <= w_ie_nxt & w_match_nxt;
      if (w_wr_ctrl) begin
        r_oneshot <= wdata[TC_ONESHOT];
        r_src     <= wdata[TC_SRC];
        r_presc   <= wdata[PL +: PW];
      end
      if (w_wr_cmp) r_cmp <= wdata;
    end
  end

  // tin synchronizer and edge flop run regardless of EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= tin;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      if (!r_en || r_src || w_presc_chg || (r_pcnt == r_presc)) r_pcnt <= '0;
      else                                                      r_pcnt <= r_pcnt + PW'(1);
      r_tick <= r_en & (r_src ? w_tin_rise : (r_pcnt == r_presc));
    end
  end

  cntreg #(.WIDTH(WIDTH)) u_cntreg (
    .clk  (clk),
    .rst  (~reset),
    .wen  (w_wen),
    .din  (w_din),
    .cen  (w_cen),
    .dout (w_dout)
  );

  always_comb begin
    rdata = '0;
    if (cs && !wr) begin
      case (addr)
        TC_CTRL: begin
          rdata[TC_EN]      = r_en;
          rdata[TC_ONESHOT] = r_oneshot;
          rdata[TC_SRC]     = r_src;
          rdata[TC_IE]      = r_ie;
          rdata[PL +: PW]   = r_presc;
        end
        TC_CNT:  rdata = w_dout;
        TC_CMP:  rdata = r_cmp;
        TC_STAT: begin
          rdata[TC_ST_MATCH] = r_match;
          rdata[TC_ST_RUN]   = r_en;
        end
        default: rdata = '0;
      endcase
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with hand-computed expectations.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tin = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rv;

  timer_ctrl #(.WIDTH(32), .PW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cs),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tin   (tin),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; wdata = '0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    cs = 1'b1; wr = 1'b0; addr = a;
    #1;
    d = rdata;
    cs = 1'b0;
  endtask

  logic [31:0] exp_per [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  logic [31:0] exp_one [8]  = '{0, 1, 2, 0, 0, 0, 0, 0};

  initial begin
    // reset state
    #12;
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), rv);
      chk($sformatf("rst_reg%0d", a), rv, 32'h0);
    end
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // periodic: CMP=3, PRESC=1, EN|IE
    bus_wr(2'd2, 32'd3);
    bus_wr(2'd0, 32'h0000_0109);
    bus_rd(2'd0, rv);
    chk("ctrl_rb", rv, 32'h0000_0109);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_rd(2'd1, rv);
      chk($sformatf("per_cnt%0d", i), rv, exp_per[i]);
      chk($sformatf("per_irq%0d", i), {31'b0, irq}, (i >= 8) ? 32'h1 : 32'h0);
    end
    bus_rd(2'd3, rv);
    chk("per_stat", rv, 32'h3);
    bus_wr(2'd0, 32'h0000_0008);
    bus_wr(2'd3, 32'h1);
    chk("clr_irq", {31'b0, irq}, 32'h0);
    bus_rd(2'd3, rv);
    chk("clr_stat", rv, 32'h0);

    // one-shot: CMP=2, PRESC=0
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd2, 32'd2);
    bus_wr(2'd0, 32'h0000_0003);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_rd(2'd1, rv);
      chk($sformatf("one_cnt%0d", i), rv, exp_one[i]);
    end
    bus_rd(2'd3, rv);
    chk("one_stat", rv, 32'h1);
    bus_rd(2'd0, rv);
    chk("one_ctrl", rv, 32'h2);
    chk("one_irq", {31'b0, irq}, 32'h0);

    // external event source
    bus_wr(2'd3, 32'h1);
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd2, 32'hFFFF_FFFF);
    bus_wr(2'd0, 32'h0000_0005);
    for (int j = 0; j < 5; j++) begin
      tin = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        bus_rd(2'd1, rv);
        if (c == 2) chk($sformatf("tin%0d_before", j), rv, 32'(j));
        if (c == 3) chk($sformatf("tin%0d_after", j), rv, 32'(j + 1));
        if (c == 2) tin = 1'b0;
      end
    end
    bus_rd(2'd1, rv);
    chk("tin_total", rv, 32'd5);

    // CNT write collides with a tick
    bus_wr(2'd0, 32'h0000_0001);
    bus_wr(2'd1, 32'h0000_0100);
    bus_rd(2'd1, rv);
    chk("coll_load", rv, 32'h100);
    @(negedge clk);
    bus_rd(2'd1, rv);
    chk("coll_next", rv, 32'h101);

    // MATCH clear collides with a new match
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd2, 32'd1);
    bus_wr(2'd0, 32'h0000_0001);
    repeat (3) @(negedge clk);
    bus_wr(2'd3, 32'h1);
    bus_rd(2'd3, rv);
    chk("mclr_same", rv, 32'h3);
    @(negedge clk);
    bus_rd(2'd3, rv);
    chk("mclr_hold", rv, 32'h3);

    // reset mid-count, PRESC=5
    bus_wr(2'd0, 32'h0);
    bus_wr(2'd1, 32'd0);
    bus_wr(2'd2, 32'd100);
    bus_wr(2'd0, 32'h0000_0509);
    repeat (20) @(negedge clk);
    bus_rd(2'd1, rv);
    chk("mid_cnt", rv, 32'd3);
    chk("mid_irq", {31'b0, irq}, 32'h1);
    reset = 1'b0;
    #1;
    chk("ares_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), rv);
      chk($sformatf("ares_reg%0d", a), rv, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    bus_rd(2'd1, rv);
    chk("post_cnt", rv, 32'h0);
    bus_rd(2'd3, rv);
    chk("post_stat", rv, 32'h0);
    chk("post_irq", {31'b0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Programmable timer controller that drives one `cntreg` counter datapath. It generates the counter's count-enable from a prescaler or an external event input, and reloads the counter on compare match. It exposes a four-register CPU bus interface and raises a level interrupt on match. It sits between the peripheral bus decoder and the interrupt controller.

## Interface
- `WIDTH`, 32: counter, compare and bus data width.
- `PW`, 8: prescaler width; requires `8+PW <= WIDTH`.

- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cs` in 1: bus select.
- `wr` in 1: write strobe; valid only with `cs`.
- `addr` in 2: register select.
- `wdata` in WIDTH: write data.
- `rdata` out WIDTH: read data; combinational; 0 when `!cs || wr`.
- `tin` in 1: asynchronous external event input.
- `irq` out 1: interrupt, `IE & MATCH`, driven from flops.

## Operation
- Register map:
  - 0 CTRL: bit0 EN, bit1 ONESHOT, bit2 SRC (0 = prescaled clk, 1 = `tin` rising edge), bit3 IE, bits[8+PW-1:8] PRESC. Read-back exact; other bits read 0.
  - 1 CNT: read returns `cntreg` dout. Write loads `wdata` via `cntreg` wen.
  - 2 CMP: compare value, read/write.
  - 3 STAT: bit0 MATCH (sticky; write 1 clears), bit1 RUN (=EN, read-only).
- Reset (`reset`=0): CTRL, CMP, MATCH, prescaler, sync flops and counter all 0. `irq`=0.
- Tick generation, only while EN=1:
  - SRC=0: `pcnt` increments each clk. When `pcnt==PRESC`, a tick occurs and `pcnt` returns to 0. PRESC=0 gives a tick every clk.
  - SRC=1: `tin` passes a 2-flop synchronizer plus an edge flop. One tick per rising edge.
  - EN=0: `pcnt` held at 0; no ticks. Edge-detect flops keep sampling so a stale edge is not seen on enable.
- Per tick:
  - If `cnt==CMP`: match. Drive wen=1, din=0, cen=0, which clears the counter. Set MATCH. If ONESHOT, clear EN.
  - Otherwise drive cen=1, and the counter increments.
  - Count wraps modulo 2^WIDTH if CMP is never reached.
- Priority in a single cycle, highest first:
  1. CPU write to CNT: wen=1, din=`wdata`, cen=0. The tick is dropped and no match is evaluated.
  2. Match reload.
  3. Increment.
- MATCH set and CPU write-1-clear in the same cycle: set wins.
- CTRL write takes effect next cycle. A write that changes PRESC resets `pcnt` to 0.
- A one-shot EN clear and a CPU CTRL write in the same cycle: the CPU value wins.

## Timing
- The tick is a registered decision. cen/wen to `cntreg` are asserted in the tick cycle, and the new count is visible on CNT read the next cycle.
- SRC=0, PRESC=p: the counter advances once every p+1 clks. The first tick is p+1 clks after the EN write cycle.
- SRC=1: the counter changes 3 clks after a `tin` rising edge. `tin` high and low periods must each be ≥2 clks.
- MATCH and `irq` rise in the cycle after the match tick.
- Period in periodic mode is (CMP+1)·(PRESC+1) clks.
- Reset mid-count: all state clears asynchronously and `irq` drops immediately.

## Structure
- Shared package / header holds:
  - address constants `TC_CTRL`=0, `TC_CNT`=1, `TC_CMP`=2, `TC_STAT`=3;
  - CTRL bit positions `TC_EN`=0, `TC_ONESHOT`=1, `TC_SRC`=2, `TC_IE`=3, `TC_PRESC_LSB`=8;
  - STAT bit positions.
- One sub-module: `cntreg` (WIDTH passed through) as the counter datapath. Its active-high reset is driven by `~reset`.
- Prescaler, synchronizer and register file stay inline. Target size is about 150–250 lines.

## Test plan
- Reset, then read all four addresses → 0 each; `irq`=0.
- CMP=3, PRESC=1, CTRL=EN|IE:
  - counter sequence 0,1,2,3,0 with each value held 2 clks;
  - MATCH and `irq`=1 one cycle after 3→0;
  - STAT write 1 → `irq`=0.
- ONESHOT: CMP=2, PRESC=0, CTRL=EN|ONESHOT:
  - counter 0,1,2,0 then stays 0;
  - RUN reads 0; MATCH=1.
- SRC=1, CMP=0xFFFFFFFF, 5 `tin` pulses (3 clks high, 3 clks low) → CNT reads 5, with each increment 3 clks after its edge.
- Collisions:
  - CPU writes CNT=0x100 in the same cycle as a tick → CNT=0x100; that tick is lost.
  - MATCH clear in the same cycle as a new match → MATCH stays 1.
- Assert `reset` low mid-count with PRESC=5 → all registers 0 asynchronously. After release, no tick until EN is rewritten.
